// File: rtl/exec_pkg.sv
// Shared constants for the 8-bit execute stage: data width, opcodes and FSM states.
package exec_pkg;

  localparam int DW = 8;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_ADC = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_CMP = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_NOT = 4'h7;
  localparam logic [3:0] OP_SHL = 4'h8;
  localparam logic [3:0] OP_SHR = 4'h9;
  localparam logic [3:0] OP_ROL = 4'hA;
  localparam logic [3:0] OP_ROR = 4'hB;
  localparam logic [3:0] OP_INC = 4'hC;
  localparam logic [3:0] OP_DEC = 4'hD;
  localparam logic [3:0] OP_PASS = 4'hE;
  localparam logic [3:0] OP_MUL = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_WB   = 2'd3
  } state_t;

endpackage

// File: rtl/exec_alu8.sv
// Combinational single-cycle ALU: result plus carry/borrow and signed overflow.
module exec_alu8
  import exec_pkg::*;
(
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          cin,
  input  logic [3:0]    op,
  output logic [DW-1:0] y,
  output logic          c,
  output logic          v
);

  logic [DW:0]   sum_add;
  logic [DW:0]   sum_sub;
  logic [DW-1:0] add_b;
  logic [DW-1:0] sub_b;
  logic          add_cin;

  always_comb begin
    add_b   = b;
    sub_b   = b;
    add_cin = 1'b0;
    case (op)
      OP_ADC:  add_cin = cin;
      OP_INC:  add_b   = DW'(1);
      OP_DEC:  sub_b   = DW'(1);
      default: ;
    endcase
    // Bit DW of the subtract is the borrow, i.e. a < sub_b unsigned
    sum_add = {1'b0, a} + {1'b0, add_b} + {{DW{1'b0}}, add_cin};
    sum_sub = {1'b0, a} - {1'b0, sub_b};

    y = '0;
    c = 1'b0;
    v = 1'b0;
    case (op)
      OP_ADD, OP_ADC, OP_INC: begin
        y = sum_add[DW-1:0];
        c = sum_add[DW];
        v = (a[DW-1] == add_b[DW-1]) && (y[DW-1] != a[DW-1]);
      end
      OP_SUB, OP_CMP, OP_DEC: begin
        y = sum_sub[DW-1:0];
        c = sum_sub[DW];
        v = (a[DW-1] != sub_b[DW-1]) && (y[DW-1] != a[DW-1]);
      end
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOT:  y = ~a;
      OP_SHL:  begin y = {a[DW-2:0], 1'b0};     c = a[DW-1]; end
      OP_SHR:  begin y = {1'b0, a[DW-1:1]};     c = a[0];    end
      OP_ROL:  begin y = {a[DW-2:0], a[DW-1]};  c = a[DW-1]; end
      OP_ROR:  begin y = {a[0], a[DW-1:1]};     c = a[0];    end
      OP_PASS: y = b;
      default: ;
    endcase
  end

endmodule

// File: rtl/exec_unit.sv
// Execute stage FSM with operand latches, flag registers and write-back strobe.
// EXEC_MUL_EN enables the 8-cycle shift-add multiply on opcode F; otherwise F is illegal.
module exec_unit
  import exec_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [3:0]    op,
  input  logic [DW-1:0] opa,
  input  logic [DW-1:0] opb,
  input  logic          csel,
  input  logic [1:0]    dst,
  output logic [DW-1:0] result,
  output logic          mrwe,
  output logic          wa1,
  output logic          wa0,
  output logic          busy,
  output logic          done,
  output logic          fz,
  output logic          fn,
  output logic          fc,
  output logic          fv
);

  state_t        state_reg, state_next;
  logic [3:0]    op_reg;
  logic [DW-1:0] a_reg, b_reg;
  logic          cin_reg;
  logic [1:0]    dst_reg;
  logic [DW-1:0] result_reg;
  logic          mrwe_reg, done_reg;
  logic [1:0]    wa_reg;
  logic [3:0]    flags_reg;

  logic [DW-1:0] alu_y;
  logic          alu_c, alu_v;
  logic          is_mul, mul_last;
  logic [DW-1:0] wb_y;
  logic          wb_c, wb_v, wb_legal, wb_load;

  exec_alu8 u_alu (
    .a   (a_reg),
    .b   (b_reg),
    .cin (cin_reg),
    .op  (op_reg),
    .y   (alu_y),
    .c   (alu_c),
    .v   (alu_v)
  );

`ifdef EXEC_MUL_EN
  logic [2*DW-1:0] prod_reg, mcand_reg, prod_next;
  logic [DW-1:0]   mplier_reg;
  logic [2:0]      cnt_reg;

  assign is_mul    = (op_reg == OP_MUL);
  assign mul_last  = (state_reg == ST_MUL) && (cnt_reg == 3'd7);
  assign prod_next = prod_reg + (mplier_reg[0] ? mcand_reg : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_reg   <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      cnt_reg    <= '0;
    end else if (state_reg == ST_EXEC) begin
      prod_reg   <= '0;
      mcand_reg  <= {{DW{1'b0}}, a_reg};
      mplier_reg <= b_reg;
      cnt_reg    <= '0;
    end else if (state_reg == ST_MUL) begin
      prod_reg   <= prod_next;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      cnt_reg    <= cnt_reg + 3'd1;
    end
  end

  assign wb_y     = mul_last ? prod_next[DW-1:0] : alu_y;
  assign wb_c     = mul_last ? (|prod_next[2*DW-1:DW]) : alu_c;
  assign wb_v     = mul_last ? 1'b0 : alu_v;
  assign wb_legal = 1'b1;
`else
  assign is_mul   = 1'b0;
  assign mul_last = 1'b0;
  assign wb_y     = alu_y;
  assign wb_c     = alu_c;
  assign wb_v     = alu_v;
  assign wb_legal = (op_reg != OP_MUL);
`endif

  // High only on the edge that enters WB, from either EXEC or the last multiply step
  assign wb_load = ((state_reg == ST_EXEC) && !is_mul) || mul_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start) state_next = ST_EXEC;
      ST_EXEC: state_next = is_mul ? ST_MUL : ST_WB;
`ifdef EXEC_MUL_EN
      ST_MUL:  if (mul_last) state_next = ST_WB;
`endif
      ST_WB:   state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg     <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      cin_reg    <= 1'b0;
      dst_reg    <= '0;
      result_reg <= '0;
      mrwe_reg   <= 1'b0;
      done_reg   <= 1'b0;
      wa_reg     <= '0;
      flags_reg  <= '0;
    end else begin
      mrwe_reg <= 1'b0;
      done_reg <= 1'b0;
      wa_reg   <= '0;
      if ((state_reg == ST_IDLE) && start) begin
        op_reg  <= op;
        a_reg   <= opa;
        b_reg   <= opb;
        cin_reg <= csel;
        dst_reg <= dst;
      end
      if (wb_load) begin
        done_reg <= 1'b1;
        wa_reg   <= dst_reg;
        if (wb_legal) begin
          result_reg <= wb_y;
          mrwe_reg   <= (op_reg != OP_CMP);
          flags_reg  <= {(wb_y == '0), wb_y[DW-1], wb_c, wb_v};
        end
      end
    end
  end

  assign result = result_reg;
  assign mrwe   = mrwe_reg;
  assign done   = done_reg;
  assign wa1    = wa_reg[1];
  assign wa0    = wa_reg[0];
  assign busy   = (state_reg != ST_IDLE);
  assign fz     = flags_reg[3];
  assign fn     = flags_reg[2];
  assign fc     = flags_reg[1];
  assign fv     = flags_reg[0];

endmodule

// File: tb/tb_exec_unit.sv
// Scoreboard bench for exec_unit: a behavioural model pushes expectations at START,
// and each DONE pops one and compares result, strobe, address, flags and latency.
module tb_exec_unit;

  logic       clk = 1'b0;
  logic       rst_n, start, csel;
  logic [3:0] op;
  logic [7:0] opa, opb;
  logic [1:0] dst;
  logic [7:0] result;
  logic       mrwe, wa1, wa0, busy, done, fz, fn, fc, fv;

  always #5 clk = ~clk;

  exec_unit dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .opa    (opa),
    .opb    (opb),
    .csel   (csel),
    .dst    (dst),
    .result (result),
    .mrwe   (mrwe),
    .wa1    (wa1),
    .wa0    (wa0),
    .busy   (busy),
    .done   (done),
    .fz     (fz),
    .fn     (fn),
    .fc     (fc),
    .fv     (fv)
  );

  typedef struct {
    logic [7:0] res;
    logic       mrwe;
    logic [1:0] wa;
    logic [3:0] flg;
    int         lat;
  } exp_t;

  exp_t       sb[$];
  int         n_chk = 0;
  int         n_err = 0;
  logic [7:0] m_res;
  logic [3:0] m_flg;

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_push(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                            input logic ci, input logic [1:0] d);
    int         ua, ub, sa, sbv, full, sfull;
    logic [7:0] r;
    logic       c, v;
    bit         arith, legal;
    exp_t       e;
    ua = a; ub = b; sa = $signed(a); sbv = $signed(b);
    full = 0; sfull = 0; r = 8'h00; c = 1'b0; v = 1'b0; arith = 0; legal = 1;
    case (o)
      4'h0: begin full = ua + ub;      sfull = sa + sbv;      c = (full > 255); arith = 1; end
      4'h1: begin full = ua + ub + ci; sfull = sa + sbv + ci; c = (full > 255); arith = 1; end
      4'h2, 4'h3: begin full = ua - ub; sfull = sa - sbv; c = (ua < ub); arith = 1; end
      4'h4: r = a & b;
      4'h5: r = a | b;
      4'h6: r = a ^ b;
      4'h7: r = ~a;
      4'h8: begin r = a << 1; c = a[7]; end
      4'h9: begin r = a >> 1; c = a[0]; end
      4'hA: begin r = (a << 1) | (a >> 7); c = a[7]; end
      4'hB: begin r = (a >> 1) | (a << 7); c = a[0]; end
      4'hC: begin full = ua + 1; sfull = sa + 1; c = (ua == 255); arith = 1; end
      4'hD: begin full = ua - 1; sfull = sa - 1; c = (ua == 0);   arith = 1; end
      4'hE: r = b;
      default: begin
`ifdef EXEC_MUL_EN
        full = ua * ub; r = full[7:0]; c = (full > 255);
`else
        legal = 0;
`endif
      end
    endcase
    if (arith) begin
      r = full[7:0];
      v = (sfull > 127) || (sfull < -128);
    end
    if (legal) begin
      m_res = r;
      m_flg = {(r == 8'h00), r[7], c, v};
    end
    e.res  = m_res;
    e.flg  = m_flg;
    e.wa   = d;
    e.mrwe = legal && (o != 4'h3);
    e.lat  = 2;
`ifdef EXEC_MUL_EN
    if (o == 4'hF) e.lat = 10;
`endif
    sb.push_back(e);
  endtask

  // hold=1 keeps START high (with junk operands) for the whole busy period and WB
  task automatic run_op(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                        input logic ci, input logic [1:0] d, input bit hold);
    exp_t e;
    int   lat;
    @(negedge clk);
    start = 1'b1; op = o; opa = a; opb = b; csel = ci; dst = d;
    model_push(o, a, b, ci, d);
    @(negedge clk);
    lat = 1;
    start = hold; op = 4'($urandom); opa = 8'($urandom); opb = 8'($urandom);
    csel = 1'($urandom); dst = 2'($urandom);
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    check("latency", 16'(lat), 16'(e.lat));
    if (done) begin
      check("result", {8'h00, result}, {8'h00, e.res});
      check("mrwe", {15'h0, mrwe}, {15'h0, e.mrwe});
      check("wa", {14'h0, wa1, wa0}, {14'h0, e.wa});
      check("flags", {12'h0, fz, fn, fc, fv}, {12'h0, e.flg});
      check("busy_wb", {15'h0, busy}, 16'h1);
    end
    $display("op=%h a=%h b=%h cin=%0d dst=%0d -> result=%h mrwe=%0d flags(zncv)=%b%b%b%b lat=%0d",
             o, a, b, ci, d, result, mrwe, fz, fn, fc, fv, lat);
    @(negedge clk);
    start = 1'b0;
    check("after_wb", {13'h0, mrwe, done, busy}, 16'h0);
    repeat (2) @(negedge clk);
    check("idle_hold", {14'h0, busy, done}, 16'h0);
  endtask

  task automatic reset_mid_op();
    bit seen;
    seen = 0;
    @(negedge clk);
    start = 1'b1; opa = 8'h12; opb = 8'h34; csel = 1'b0; dst = 2'd1;
`ifdef EXEC_MUL_EN
    op = 4'hF;
`else
    op = 4'h0;
`endif
    @(negedge clk);
    start = 1'b0;
`ifdef EXEC_MUL_EN
    repeat (4) @(negedge clk);
`endif
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_result", {8'h00, result}, 16'h0);
    check("rst_mid_ctl", {11'h0, mrwe, done, busy, wa1, wa0}, 16'h0);
    check("rst_mid_flags", {12'h0, fz, fn, fc, fv}, 16'h0);
    m_res = 8'h00;
    m_flg = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (mrwe || done) seen = 1;
    end
    check("rst_no_wb", {15'h0, seen}, 16'h0);
    check("rst_busy", {15'h0, busy}, 16'h0);
    $display("reset mid-op -> result=%h busy=%0d", result, busy);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 4'h0; opa = 8'h00; opb = 8'h00; csel = 1'b0; dst = 2'd0;
    m_res = 8'h00; m_flg = 4'h0;
    repeat (2) @(negedge clk);
    check("reset_result", {8'h00, result}, 16'h0);
    check("reset_ctl", {11'h0, mrwe, done, busy, wa1, wa0}, 16'h0);
    check("reset_flags", {12'h0, fz, fn, fc, fv}, 16'h0);
    rst_n = 1'b1;

    run_op(4'h0, 8'h7F, 8'h01, 1'b0, 2'd2, 0);
    reset_mid_op();
    run_op(4'h0, 8'h7F, 8'h01, 1'b0, 2'd2, 0);
    run_op(4'h3, 8'h10, 8'h20, 1'b0, 2'd1, 0);
    run_op(4'h1, 8'hFF, 8'h00, 1'b1, 2'd0, 1);
    run_op(4'hF, 8'h12, 8'h34, 1'b0, 2'd3, 1);
    run_op(4'hF, 8'h0F, 8'h0F, 1'b0, 2'd2, 0);
    run_op(4'hC, 8'hFF, 8'h00, 1'b0, 2'd1, 0);
    run_op(4'hD, 8'h00, 8'h00, 1'b0, 2'd2, 0);
    run_op(4'hD, 8'h80, 8'h00, 1'b0, 2'd3, 0);
    run_op(4'h2, 8'h80, 8'h01, 1'b0, 2'd0, 0);
    run_op(4'hB, 8'h01, 8'h00, 1'b0, 2'd1, 0);
    run_op(4'h8, 8'h80, 8'h00, 1'b0, 2'd2, 0);
    run_op(4'hE, 8'h00, 8'h00, 1'b0, 2'd3, 0);
    for (int i = 0; i < 30; i++) begin
      run_op(4'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 2'($urandom),
             bit'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
